// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters.
// A grant lasts for a whole message unless the length or stall limit forces a release.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int MAX_MSG_LEN   = 64,
    parameter int STALL_TIMEOUT = 100000,
    localparam int GW           = $clog2(NREQ),
    localparam int SW           = $clog2(STALL_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_tx_valid,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_ready,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              msg_abort
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [7:0]    LEN_LAST   = 8'(MAX_MSG_LEN - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_INIT  = GW'(NREQ - 1);

    state_t        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_grant_q;
    logic          busy_q;
    logic          abort_q;
    logic [7:0]    byte_cnt_q;
    logic [SW-1:0] stall_cnt_q;

    logic          own_s;
    logic          owner_valid_s;
    logic          owner_last_s;
    logic [7:0]    owner_data_s;
    logic          xfer_s;
    logic          done_s;
    logic          len_hit_s;
    logic          stall_hit_s;
    logic          pick_found_s;
    logic [GW-1:0] pick_idx_s;
    int            cand_s;

    assign own_s         = (state_q == OWN);
    assign owner_valid_s = req_valid[grant_q];
    assign owner_last_s  = req_last[grant_q];
    assign owner_data_s  = req_data[{grant_q, 3'b000} +: 8];
    assign xfer_s        = own_s & owner_valid_s & uart_tx_ready;

    // Release conditions; an end-of-message byte takes precedence over the length limit.
    assign done_s      = xfer_s & owner_last_s;
    assign len_hit_s   = xfer_s & ~owner_last_s & (byte_cnt_q == LEN_LAST);
    assign stall_hit_s = own_s & ~owner_valid_s & (stall_cnt_q == STALL_LAST);

    // Round-robin pick: scan from farthest to nearest so the nearest index after last_grant wins.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_s = (int'(last_grant_q) + k) % NREQ;
            if (req_valid[GW'(cand_s)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = GW'(cand_s);
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Owner pass-through to the transmitter; everything is quiet while idle.
    always_comb begin
        req_ready     = '0;
        uart_tx_valid = 1'b0;
        uart_tx_data  = 8'h00;
        if (own_s) begin
            uart_tx_valid      = owner_valid_s;
            uart_tx_data       = owner_data_s;
            req_ready[grant_q] = uart_tx_ready;
        end else begin
            req_ready     = '0;
            uart_tx_valid = 1'b0;
            uart_tx_data  = 8'h00;
        end
    end

    // Grant FSM with byte and stall counters and the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
            busy_q       <= 1'b0;
            abort_q      <= 1'b0;
            byte_cnt_q   <= 8'd0;
            stall_cnt_q  <= '0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found_s) begin
                        state_q     <= OWN;
                        grant_q     <= pick_idx_s;
                        busy_q      <= 1'b1;
                        byte_cnt_q  <= 8'd0;
                        stall_cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                OWN: begin
                    if (done_s || len_hit_s || stall_hit_s) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        last_grant_q <= grant_q;
                        abort_q      <= ~done_s;
                    end else if (xfer_s) begin
                        byte_cnt_q  <= byte_cnt_q + 8'd1;
                        stall_cnt_q <= '0;
                    end else if (!owner_valid_s) begin
                        stall_cnt_q <= stall_cnt_q + SW'(1);
                    end else begin
                        stall_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign msg_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a random phase, every cycle compared
// against a message-level reference model built from integer owner/count bookkeeping.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int MAXL  = 4;
    localparam int STALL = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              uart_tx_valid;
    logic [7:0]        uart_tx_data;
    logic              uart_tx_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              msg_abort;

    uart_tx_arbiter #(.NREQ(NREQ), .MAX_MSG_LEN(MAXL), .STALL_TIMEOUT(STALL)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .msg_abort     (msg_abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Per-requester pending bytes {last, data} and whether the head byte is being offered.
    logic [8:0]      q [NREQ][$];
    logic [NREQ-1:0] pres;
    bit              rand_mode;
    int              ready_mode;
    int              bp_cnt;
    bit              rst_req;

    // Reference model: owner index (-1 = nobody), previous owner, counts, expected pulse.
    int m_owner, m_last, m_gid, m_bytes, m_stall;
    bit m_abort;

    int         obs_xfer, obs_abort, total_loaded;
    logic [7:0] obs_bytes[$];
    logic [7:0] exp_bytes[$];
    int         obs_grants[$];
    bit         prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NREQ - 1;
        m_gid   = 0;
        m_bytes = 0;
        m_stall = 0;
        m_abort = 1'b0;
    endtask

    task automatic load_msg(input int i, input int len, input bit with_last);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            q[i].push_back({(with_last && k == len - 1), b});
            exp_bytes.push_back(b);
        end
    endtask

    task automatic load_byte(input int i, input logic [7:0] b, input bit l);
        q[i].push_back({l, b});
        exp_bytes.push_back(b);
    endtask

    task automatic phase_start();
        obs_xfer  = 0;
        obs_abort = 0;
        obs_bytes.delete();
        exp_bytes.delete();
        obs_grants.delete();
    endtask

    task automatic drive();
        rst = rst_req;
        for (int i = 0; i < NREQ; i++) begin
            if (!pres[i] && q[i].size() > 0) begin
                if (!rand_mode || $urandom_range(0, 3) != 0) pres[i] = 1'b1;
            end
            if (pres[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = q[i][0][7:0];
                req_last[i]         = q[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
        case (ready_mode)
            0:       uart_tx_ready = 1'b1;
            1:       uart_tx_ready = ((bp_cnt % 4) == 0);
            2:       uart_tx_ready = ($urandom_range(0, 2) != 0);
            default: uart_tx_ready = 1'b0;
        endcase
        bp_cnt++;
    endtask

    task automatic check_and_model();
        logic [NREQ-1:0] e_ready;
        logic            e_valid;
        logic [7:0]      e_data;
        int              g, c;
        bit              found, abort_n;
        g       = m_owner;
        e_ready = '0;
        e_valid = 1'b0;
        e_data  = 8'h00;
        if (g >= 0) begin
            e_valid = req_valid[g];
            e_data  = req_data[8*g +: 8];
            e_ready[g] = uart_tx_ready;
        end
        chk("busy", 32'(busy), 32'(g >= 0));
        chk("msg_abort", 32'(msg_abort), 32'(m_abort));
        chk("tx_valid", 32'(uart_tx_valid), 32'(e_valid));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        if (g >= 0) chk("grant_id", 32'(grant_id), 32'(m_gid));
        if (e_valid) chk("tx_data", 32'(uart_tx_data), 32'(e_data));

        if (uart_tx_valid && uart_tx_ready) begin
            obs_xfer++;
            obs_bytes.push_back(uart_tx_data);
        end
        if (msg_abort) obs_abort++;
        if (busy && !prev_busy) obs_grants.push_back(int'(grant_id));
        prev_busy = busy;

        abort_n = 1'b0;
        if (g < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (!found && req_valid[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_gid   = c;
                    m_bytes = 0;
                    m_stall = 0;
                end
            end
        end else if (req_valid[g] && uart_tx_ready) begin
            void'(q[g].pop_front());
            pres[g] = 1'b0;
            m_bytes++;
            m_stall = 0;
            if (req_last[g]) begin
                m_owner = -1;
                m_last  = g;
            end else if (m_bytes == MAXL) begin
                m_owner = -1;
                m_last  = g;
                abort_n = 1'b1;
            end
        end else if (!req_valid[g]) begin
            m_stall++;
            if (m_stall == STALL) begin
                m_owner = -1;
                m_last  = g;
                abort_n = 1'b1;
            end
        end else begin
            m_stall = 0;
        end
        m_abort = abort_n;
        if (rst) model_reset();
    endtask

    task automatic step();
        drive();
        #1;
        check_and_model();
        @(negedge clk);
    endtask

    function automatic bit all_idle();
        bit r;
        r = (m_owner < 0) && !m_abort && (pres == '0);
        for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic run_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(all_idle()), 32'd1);
    endtask

    task automatic check_bytes(input string tag);
        chk(tag, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
        for (int k = 0; k < exp_bytes.size() && k < obs_bytes.size(); k++)
            chk(tag, 32'(obs_bytes[k]), 32'(exp_bytes[k]));
    endtask

    task automatic check_grants(input string tag, input int n, input int g0, input int g1,
                                input int g2, input int g3, input int g4);
        int e[5];
        e = '{g0, g1, g2, g3, g4};
        chk(tag, 32'(obs_grants.size()), 32'(n));
        for (int k = 0; k < n && k < obs_grants.size(); k++)
            chk(tag, 32'(obs_grants[k]), 32'(e[k]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_req = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; uart_tx_ready = 1'b0;
        pres = '0; rand_mode = 1'b0; ready_mode = 0; bp_cnt = 0; prev_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_req = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_abort", 32'(msg_abort), 32'd0);
        chk("rst_data", 32'(uart_tx_data), 32'd0);
        @(negedge clk);
        step();

        // Single message on requester 0; the length limit coincides with last, last wins.
        phase_start();
        load_byte(0, 8'h55, 1'b0);
        load_byte(0, 8'h00, 1'b0);
        load_byte(0, 8'hFF, 1'b0);
        load_byte(0, 8'hA5, 1'b1);
        run_drain("t1_drain", 100);
        check_bytes("t1_bytes");
        check_grants("t1_grant", 1, 0, 0, 0, 0, 0);
        chk("t1_abort", 32'(obs_abort), 32'd0);

        // Contention after a reset: 0,1,2, then 3 before a re-armed 0.
        rst_req = 1'b1; step(); rst_req = 1'b0;
        phase_start();
        load_msg(0, 2, 1'b1);
        load_msg(1, 2, 1'b1);
        load_msg(2, 2, 1'b1);
        run_drain("t2_drain_a", 100);
        load_msg(3, 2, 1'b1);
        load_msg(0, 2, 1'b1);
        run_drain("t2_drain_b", 100);
        check_grants("t2_grant", 5, 0, 1, 2, 3, 0);
        check_bytes("t2_bytes");
        chk("t2_abort", 32'(obs_abort), 32'd0);

        // Back-pressure: ready one cycle in four.
        phase_start();
        ready_mode = 1; bp_cnt = 1;
        load_byte(1, 8'h11, 1'b0);
        load_byte(1, 8'h22, 1'b0);
        load_byte(1, 8'h33, 1'b1);
        run_drain("t3_drain", 200);
        chk("t3_xfers", 32'(obs_xfer), 32'd3);
        check_bytes("t3_bytes");
        check_grants("t3_grant", 1, 1, 0, 0, 0, 0);
        ready_mode = 0;

        // Length abort on req2, req3 waiting; req2's unterminated tail then stalls out.
        phase_start();
        load_msg(2, 6, 1'b0);
        step();
        load_msg(3, 1, 1'b1);
        run_drain("t4_drain", 200);
        check_grants("t4_grant", 3, 2, 3, 2, 0, 0);
        chk("t4_xfers", 32'(obs_xfer), 32'd7);
        chk("t4_aborts", 32'(obs_abort), 32'd2);

        // Stall abort: one byte then silence.
        phase_start();
        load_msg(0, 1, 1'b0);
        run_drain("t5_drain", 100);
        chk("t5_aborts", 32'(obs_abort), 32'd1);
        chk("t5_xfers", 32'(obs_xfer), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);

        // Reset during req1's second byte; next grant goes to req0.
        phase_start();
        load_msg(1, 3, 1'b1);
        for (int n = 0; n < 20 && obs_xfer < 1; n++) step();
        chk("t6_first", 32'(obs_xfer), 32'd1);
        rst_req = 1'b1; ready_mode = 3;
        step();
        rst_req = 1'b0; ready_mode = 0;
        q[1].delete(); pres[1] = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_gid", 32'(grant_id), 32'd0);
        chk("t6_valid", 32'(uart_tx_valid), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd0);
        obs_grants.delete();
        load_msg(0, 1, 1'b1);
        load_msg(1, 2, 1'b1);
        @(negedge clk);
        run_drain("t6_drain", 100);
        check_grants("t6_grant", 2, 0, 1, 0, 0, 0);
        chk("t6_aborts", 32'(obs_abort), 32'd0);

        // Random traffic: every byte delivered exactly once.
        phase_start();
        rand_mode = 1'b1; ready_mode = 2; total_loaded = 0;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 1) == 1) begin
                    int len;
                    len = int'($urandom_range(1, 6));
                    load_msg(i, len, 1'b1);
                    total_loaded += len;
                end
            end
            repeat (40) step();
        end
        run_drain("t7_drain", 3000);
        chk("t7_xfers", 32'(obs_xfer), 32'(total_loaded));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter sharing the single `uart` transmitter among NREQ byte-stream requesters, such as a debug console, status reporter and loader echo. Each requester sends a message: a sequence of bytes terminated by `req_last`. Once granted, a requester keeps the transmitter until its message completes, so bytes from different requesters never interleave. The arbiter sits between the requesters and the `tx_valid`/`tx_data`/`tx_ready` port of `uart`. Forced release guards against a runaway or stalled message.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_MSG_LEN, 64, maximum bytes per grant before forced release (1..255).
- STALL_TIMEOUT, 100000, consecutive cycles a granted requester may hold `req_valid` low before forced release (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  marks the final byte of a message; qualified by `req_valid`.
- req_ready  out  NREQ  per-requester accept.
- uart_tx_valid  out  1  to `uart` `tx_valid`.
- uart_tx_data  out  8  to `uart` `tx_data`.
- uart_tx_ready  in  1  from `uart` `tx_ready`.
- grant_id  out  clog2(NREQ)  index of the current owner; valid while `busy`=1.
- busy  out  1  high while a requester holds the grant.
- msg_abort  out  1  one-cycle pulse on forced release.

Behaviour:
- Transfer definition: a transfer occurs on a cycle where `uart_tx_valid`=1 and `uart_tx_ready`=1.
- Reset values:
  - All outputs are 0: `req_ready`, `uart_tx_valid`, `uart_tx_data`, `grant_id`, `busy`, `msg_abort`.
  - The FSM is in IDLE.
  - `last_grant` = NREQ-1, so requester 0 has first priority after reset.
  - Byte counter and stall counter are 0.
- FSM has two states: IDLE and OWN.
- IDLE:
  - `uart_tx_valid`=0 and all `req_ready`=0.
  - If any `req_valid` is set, choose the first asserted index scanning `last_grant`+1, +2, … modulo NREQ.
  - On the next clock: `grant_id` = chosen index, `busy`=1, go to OWN, clear both counters.
  - Arbitration latency is one cycle; no byte is accepted in the deciding cycle.
- OWN, with owner g:
  - Combinational pass-through:
    - `uart_tx_valid` = `req_valid[g]`
    - `uart_tx_data` = `req_data[g]`
    - `req_ready[g]` = `uart_tx_ready`
    - every other `req_ready` bit = 0.
  - On a transfer: byte counter increments and stall counter clears.
  - On a transfer with `req_last[g]`=1:
    - go to IDLE, `busy`=0, `last_grant` = g.
    - `msg_abort` stays 0.
  - Forced release by length: on a transfer without `req_last` where the byte counter reaches MAX_MSG_LEN (i.e. the MAX_MSG_LEN-th byte):
    - go to IDLE, `last_grant` = g, `msg_abort`=1 for one cycle.
    - That byte is still delivered.
  - Stall counter: increments on each cycle with `req_valid[g]`=0.
  - Forced release by stall: when the stall counter reaches STALL_TIMEOUT, release with the same effects as the length case (no byte involved).
  - A cycle with `req_valid[g]`=1 and `uart_tx_ready`=0 is back-pressure, not a stall.
  - If `req_last` and a limit coincide on the same transfer, `req_last` wins: no `msg_abort`.
- Leaving OWN: `uart_tx_valid` and `req_ready` drop combinationally in the first IDLE cycle.
- Re-grant: a released requester may be re-granted only if no other requester is valid (round-robin fairness). Minimum gap between messages is one IDLE cycle.
- Data stability: `uart_tx_data` only needs to be meaningful while `uart_tx_valid`=1. Requesters must hold data and `last` stable while valid and not ready.
- Reset mid-message: immediate return to IDLE with the reset values above. A partially sent message is not resumed. `msg_abort` is not pulsed.
- Counter widths: byte counter is 8 bits; stall counter is clog2(STALL_TIMEOUT+1) bits. Neither counter can wrap, because release occurs at the limit.

Test Plan:
- Single message: after reset, req0 sends 0x55, 0x00, 0xFF, 0xA5 (last on 0xA5) with `uart_tx_ready` always 1.
  - Required: `busy` rises 1 cycle after `req_valid[0]`; the four bytes appear in order on `uart_tx_data`; `busy` falls after the 0xA5 transfer; `msg_abort` never asserts.
- Contention: req0, req1 and req2 each hold a 2-byte message ready at the same cycle.
  - Required: grant order 0, 1, 2; no interleaving; then req0 re-arms and req3 is valid → req3 is granted before req0.
- Back-pressure: toggle `uart_tx_ready` 1-in-4 while req1 sends 0x11, 0x22, 0x33.
  - Required: exactly 3 transfers; `req_ready[1]` mirrors `uart_tx_ready`; other `req_ready` bits stay 0.
- Length abort: MAX_MSG_LEN=4; req2 sends 6 bytes without `last`.
  - Required: 4 bytes transferred; `msg_abort` pulses on the cycle after the 4th transfer; a waiting req3 is granted next.
- Stall abort: STALL_TIMEOUT=10; req0 sends 1 byte, then drops `req_valid`.
  - Required: release with a `msg_abort` pulse 10 cycles later; `busy`=0.
- Reset mid-message: assert `rst` for one cycle during req1's 2nd byte.
  - Required: all outputs return to 0; next grant goes to req0 if valid; no `msg_abort`.
- Loopback with `uart` (115200 baud, 100 MHz clock): two requesters each send a message.
  - Required: the `rxd` side receives the bytes in grant order with no frame error.
